// File: rtl/nco_tunable.sv
// nco_tunable: tunable numerically controlled oscillator.
//
// A phase accumulator advances by freq_i on every ce_i cycle. The top
// PHASE_WIDTH bits plus phase_off_i form the sample phase. That phase drives
// a quarter-wave sin/cos table through a 3-stage pipeline:
// phase register, table read, quadrant sign/select.
//
// Ports
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   ce_i        : advance the accumulator and emit one sample
//   sync_i      : clear the phase accumulator
//   freq_i      : unsigned phase increment per sample (ACC_WIDTH bits)
//   phase_off_i : unsigned phase offset added after the accumulator
//   valid_o     : sin_o/cos_o carry a new sample (3 cycles after ce_i)
//   sin_o/cos_o : signed DATA_WIDTH sample values, held between samples
//
// The table contents are computed at elaboration by table_word(). They are
// the same words that the exported INIT_FNAME hex file holds:
// {round(A*sin), round(A*cos)} over the first quadrant.

module nco_tunable #(
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int PHASE_WIDTH = 12,
  parameter     INIT_FNAME  = "export_nco_sin.csv"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce_i,
  input  logic                         sync_i,
  input  logic [ACC_WIDTH-1:0]         freq_i,
  input  logic [PHASE_WIDTH-1:0]       phase_off_i,
  output logic                         valid_o,
  output logic signed [DATA_WIDTH-1:0] sin_o,
  output logic signed [DATA_WIDTH-1:0] cos_o
);

  localparam int N = 2 ** (PHASE_WIDTH - 2);

  // 2*pi in Q30 fixed point.
  localparam longint TWO_PI_Q30 = 64'sd6746518852;

  // One table word: a Taylor series in Q30, then rounding to the output scale.
  // The angle is below pi/2, so both results are non-negative. They are
  // clamped to [0, A] so that negating them can never overflow.
  function automatic logic [2*DATA_WIDTH-1:0] table_word(input int idx);
    longint x, x2, ts, tc, ss, cs, amp, s_v, c_v;
    x   = (longint'(idx) * TWO_PI_Q30) >>> PHASE_WIDTH;
    x2  = (x * x) >>> 30;
    ts  = x;
    ss  = x;
    tc  = 64'sd1 <<< 30;
    cs  = tc;
    for (int k = 1; k <= 7; k++) begin
      ts = -((ts * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      ss = ss + ts;
      tc = -((tc * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
      cs = cs + tc;
    end
    amp = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
    s_v = (amp * ss + (64'sd1 <<< 29)) >>> 30;
    c_v = (amp * cs + (64'sd1 <<< 29)) >>> 30;
    if (s_v < 64'sd0) s_v = 64'sd0;
    if (s_v > amp)    s_v = amp;
    if (c_v < 64'sd0) c_v = 64'sd0;
    if (c_v > amp)    c_v = amp;
    return {s_v[DATA_WIDTH-1:0], c_v[DATA_WIDTH-1:0]};
  endfunction

  logic [2*DATA_WIDTH-1:0] rom_s [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam logic [2*DATA_WIDTH-1:0] WORD = table_word(g);
    assign rom_s[g] = WORD;
  end

  logic [ACC_WIDTH-1:0]         acc_q, acc_d, acc_base_s;
  logic [PHASE_WIDTH-1:0]       p_q, p_d;
  logic                         v1_q, v2_q, valid_q, valid_d;
  logic [1:0]                   quad_q;
  logic [2*DATA_WIDTH-1:0]      rom_q;
  logic signed [DATA_WIDTH-1:0] sin_q, sin_d, cos_q, cos_d;
  logic signed [DATA_WIDTH-1:0] def_s, rev_s;

  // Stage 1 next state. sync_i zeroes the accumulator that this cycle's
  // sample sees, so sync_i together with ce_i emits phase 0 and then loads
  // freq_i.
  always_comb begin
    acc_base_s = sync_i ? '0 : acc_q;
    p_d        = acc_base_s[ACC_WIDTH-1 -: PHASE_WIDTH] + phase_off_i;
    if (ce_i) begin
      acc_d = acc_base_s + freq_i;
    end else if (sync_i) begin
      acc_d = '0;
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator, phase register and pipeline valids.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      p_q     <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      valid_q <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      v1_q    <= ce_i;
      v2_q    <= v1_q;
      valid_q <= valid_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
      if (ce_i) begin
        p_q <= p_d;
      end
    end
  end

  // Stage 2: synchronous table read. It is not reset, because the table data
  // is independent of reset.
  always_ff @(posedge clk) begin
    if (v1_q) begin
      rom_q  <= rom_s[p_q[PHASE_WIDTH-3:0]];
      quad_q <= p_q[PHASE_WIDTH-1:PHASE_WIDTH-2];
    end
  end

  assign def_s = rom_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign rev_s = rom_q[DATA_WIDTH-1:0];

  // Stage 3: quadrant fold-out. The outputs hold their value when no sample
  // is arriving.
  always_comb begin
    sin_d   = sin_q;
    cos_d   = cos_q;
    valid_d = v2_q;
    if (v2_q) begin
      case (quad_q)
        2'd0:    begin sin_d = def_s;  cos_d = rev_s;  end
        2'd1:    begin sin_d = rev_s;  cos_d = -def_s; end
        2'd2:    begin sin_d = -def_s; cos_d = -rev_s; end
        2'd3:    begin sin_d = -rev_s; cos_d = def_s;  end
        default: begin sin_d = def_s;  cos_d = rev_s;  end
      endcase
    end else begin
      sin_d = sin_q;
      cos_d = cos_q;
    end
  end

  assign valid_o = valid_q;
  assign sin_o   = sin_q;
  assign cos_o   = cos_q;

endmodule

// File: doc/nco_tunable.md
NCO_TUNABLE -- requirements
Module: nco_tunable

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed width of sin/cos outputs.
REQ-002 SHALL have parameter ACC_WIDTH, default 32: phase accumulator width (full turn = 2^ACC_WIDTH).
REQ-003 SHALL have parameter PHASE_WIDTH, default 12: LUT phase resolution; top 2 bits select the quadrant, the rest address the table.
REQ-004 SHALL have parameter INIT_FNAME, default "export_nco_sin.csv": hex table file, 2^(PHASE_WIDTH-2) words of 2*DATA_WIDTH bits.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port ce_i, input, 1: advance and emit one sample.
REQ-008 SHALL have port sync_i, input, 1: phase-accumulator clear.
REQ-009 SHALL have port freq_i, input, ACC_WIDTH: unsigned phase increment per sample.
REQ-010 SHALL have port phase_off_i, input, PHASE_WIDTH: unsigned phase offset added after the accumulator.
REQ-011 SHALL have port valid_o, output, 1: sin_o/cos_o carry a new sample.
REQ-012 SHALL have ports sin_o and cos_o, output, signed DATA_WIDTH each: sample values.

Function
REQ-013 SHALL define A = 2^(DATA_WIDTH-1)-1 and N = 2^(PHASE_WIDTH-2); table word i SHALL be {def, rev}, with def = round(A*sin(2*pi*i/2^PHASE_WIDTH)) in the upper half and rev = round(A*cos(2*pi*i/2^PHASE_WIDTH)) in the lower half.
REQ-014 SHALL update the accumulator only when ce_i=1: acc <= acc + freq_i, modulo 2^ACC_WIDTH, with silent wrap and no saturation.
REQ-015 SHALL form the sample phase at a ce_i cycle as p = acc[ACC_WIDTH-1 -: PHASE_WIDTH] + phase_off_i, modulo 2^PHASE_WIDTH, using acc before the increment of that cycle (truncation, no dithering).
REQ-016 SHALL take quadrant q = p[PHASE_WIDTH-1:PHASE_WIDTH-2] and address a = p[PHASE_WIDTH-3:0].
REQ-017 SHALL map each quadrant as follows: q0: sin=def, cos=rev. q1: sin=rev, cos=-def. q2: sin=-def, cos=-rev. q3: sin=-rev, cos=def.
REQ-018 SHALL use a 3-stage pipeline: register phase/quadrant, synchronous LUT read, then sign/select register.
REQ-019 SHALL assert valid_o exactly 3 cycles after each ce_i=1 cycle, with the matching sample, and SHALL otherwise hold valid_o=0.
REQ-020 SHALL make sin_o/cos_o hold their last value while valid_o=0.
REQ-021 SHALL preserve gaps in ce_i in the output; samples SHALL never be dropped or duplicated.
REQ-022 SHALL, when sync_i=1 and ce_i=0, set acc <= 0.
REQ-023 SHALL, when sync_i=1 and ce_i=1, use acc=0 for that cycle's sample and set acc <= freq_i.
REQ-024 SHALL sample freq_i and phase_off_i only on ce_i=1 cycles; changes SHALL take effect from the next sample with no glitch.
REQ-025 SHALL keep outputs free of overflow: negating any table value stays within ±A.

Reset
REQ-026 SHALL, while rst=1, immediately force acc=0, all pipeline valids=0, valid_o=0, sin_o=0, cos_o=0.
REQ-027 SHALL, when rst asserts mid-operation, discard in-flight samples; no valid_o SHALL follow from pre-reset ce_i.
REQ-028 SHALL accept a ce_i in the first cycle after rst deasserts, with valid_o 3 cycles later; the table contents SHALL be unaffected by reset.

Verification
REQ-029 SHALL cover: rst pulse mid-stream -> valid_o=0 and sin_o=cos_o=0 within the same cycle, and no stale valid_o afterwards.
REQ-030 SHALL cover: defaults, freq_i=0, phase_off_i=0, ce_i=1 continuous -> from cycle 3 on, sin_o=0 and cos_o=32767 on every sample.
REQ-031 SHALL cover: freq_i=2^30, ce_i continuous -> (sin,cos) = (0,32767), (32767,0), (0,-32767), (-32767,0), repeating with wrap.
REQ-032 SHALL cover: freq_i=0, phase_off_i=1024 -> sin_o=32767, cos_o=0. phase_off_i=3072 -> sin_o=-32767, cos_o=0.
REQ-033 SHALL cover: freq_i=2^30, sync_i and ce_i together on the 3rd sample -> outputs (0,32767), (32767,0), (0,32767), (32767,0).
REQ-034 SHALL cover: ce_i pattern 1,0,0,1,1 -> valid_o pattern 1,0,0,1,1 delayed by 3 cycles, with outputs held across the gaps.
